// File: rtl/mouse_tracker.sv
// PS/2 mouse receiver: deframes 11-bit PS/2 frames, assembles 3-byte movement
// packets and tracks a clamped on-screen pointer position and left button.
module mouse_tracker #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [9:0] mouseX,
  output logic [9:0] mouseY,
  output logic       mouseBotton,
  output logic       packet_valid,
  output logic       frame_error
);

  // frame state | meaning
  // IDLE        | waiting for a start bit
  // DATA        | shifting in 8 data bits, LSB first
  // PARITY      | capturing the odd-parity bit
  // STOP        | checking stop bit and parity, handing the byte on
  // packet state | meaning
  // BYTE0        | waiting for a header byte (bit3 set)
  // BYTE1        | waiting for the X movement byte
  // BYTE2        | waiting for the Y movement byte, then apply

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]     TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic signed [11:0] X_MAX   = 12'(SCREEN_W - 1);
  localparam logic signed [11:0] Y_MAX   = 12'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_t;
  typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2} pkt_t;

  frame_t frame_st;
  pkt_t   pkt_st;

  logic          clk_s1, clk_s2, clk_prev;
  logic          data_s1, data_s2;
  logic          fall;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt;
  logic          parity_bit;
  logic [TW-1:0] tmo_cnt;
  logic [4:0]    hdr;      // {y_ovf, x_ovf, y_sign, x_sign, left_button}
  logic [7:0]    byte1;

  logic signed [11:0] dx, dy, new_x, new_y;
  logic [9:0]         clamp_x, clamp_y;
  logic               parity_ok;

  assign fall = clk_prev & ~clk_s2;

  always_comb begin
    dx        = hdr[3] ? 12'sd0 : $signed({{4{hdr[1]}}, byte1});
    // shift_reg holds the third byte while its stop bit is being checked
    dy        = hdr[4] ? 12'sd0 : $signed({{4{hdr[2]}}, shift_reg});
    new_x     = $signed({2'b00, mouseX}) + dx;
    new_y     = $signed({2'b00, mouseY}) - dy;
    parity_ok = ^{shift_reg, parity_bit};
    clamp_x   = new_x[9:0];
    clamp_y   = new_y[9:0];
    if (new_x < 12'sd0)      clamp_x = 10'd0;
    else if (new_x > X_MAX)  clamp_x = X_MAX[9:0];
    if (new_y < 12'sd0)      clamp_y = 10'd0;
    else if (new_y > Y_MAX)  clamp_y = Y_MAX[9:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1       <= 1'b1;
      clk_s2       <= 1'b1;
      clk_prev     <= 1'b1;
      data_s1      <= 1'b1;
      data_s2      <= 1'b1;
      frame_st     <= IDLE;
      pkt_st       <= BYTE0;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      parity_bit   <= 1'b0;
      tmo_cnt      <= TMO_LOAD;
      hdr          <= '0;
      byte1        <= '0;
      mouseX       <= 10'(SCREEN_W / 2);
      mouseY       <= 10'(SCREEN_H / 2);
      mouseBotton  <= 1'b0;
      packet_valid <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      clk_s1       <= ps2_clk;
      clk_s2       <= clk_s1;
      clk_prev     <= clk_s2;
      data_s1      <= ps2_data;
      data_s2      <= data_s1;
      packet_valid <= 1'b0;
      frame_error  <= 1'b0;

      if (frame_st != IDLE && !fall) begin
        if (tmo_cnt == '0) begin
          frame_st    <= IDLE;
          pkt_st      <= BYTE0;
          frame_error <= 1'b1;
          tmo_cnt     <= TMO_LOAD;
        end else begin
          tmo_cnt <= tmo_cnt - 1'b1;
        end
      end

      if (fall) begin
        tmo_cnt <= TMO_LOAD;
        case (frame_st)
          IDLE: begin
            if (!data_s2) begin
              frame_st <= DATA;
              bit_cnt  <= '0;
            end
          end
          DATA: begin
            shift_reg <= {data_s2, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) frame_st <= PARITY;
          end
          PARITY: begin
            parity_bit <= data_s2;
            frame_st   <= STOP;
          end
          default: begin
            frame_st <= IDLE;
            if (data_s2 && parity_ok) begin
              case (pkt_st)
                BYTE0: begin
                  if (shift_reg[3]) begin
                    hdr    <= {shift_reg[7:4], shift_reg[0]};
                    pkt_st <= BYTE1;
                  end
                end
                BYTE1: begin
                  byte1  <= shift_reg;
                  pkt_st <= BYTE2;
                end
                BYTE2: begin
                  mouseX       <= clamp_x;
                  mouseY       <= clamp_y;
                  mouseBotton  <= hdr[0];
                  packet_valid <= 1'b1;
                  pkt_st       <= BYTE0;
                end
                default: pkt_st <= BYTE0;
              endcase
            end else begin
              frame_error <= 1'b1;
              pkt_st      <= BYTE0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mouse_tracker.sv
// Bench for mouse_tracker: PS/2 frame driver plus a packet-level pointer model
// checked after every byte, with directed scenarios and randomized traffic.
module tb_mouse_tracker;

  localparam int W   = 640;
  localparam int H   = 480;
  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [9:0] mouseX, mouseY;
  logic       mouseBotton, packet_valid, frame_error;

  mouse_tracker #(.SCREEN_W(W), .SCREEN_H(H), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .mouseX(mouseX), .mouseY(mouseY), .mouseBotton(mouseBotton),
    .packet_valid(packet_valid), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int pv_cnt = 0;
  int fe_cnt = 0;

  // reference state
  int       rx, ry, rb, exp_pv, exp_fe;
  bit [7:0] q[$];

  always @(negedge clk) begin
    if (packet_valid) pv_cnt++;
    if (frame_error)  fe_cnt++;
  end

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk_eq({tag, ".x"},   int'(mouseX), rx);
    chk_eq({tag, ".y"},   int'(mouseY), ry);
    chk_eq({tag, ".btn"}, int'(mouseBotton), rb);
    chk_eq({tag, ".pv"},  pv_cnt, exp_pv);
    chk_eq({tag, ".fe"},  fe_cnt, exp_fe);
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0)  return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    rx = W / 2; ry = H / 2; rb = 0;
    q.delete();
  endtask

  task automatic model_byte(input bit [7:0] b, input bit good);
    int mx, my;
    if (!good) begin
      exp_fe++;
      q.delete();
      return;
    end
    if (q.size() == 0 && !b[3]) return;
    q.push_back(b);
    if (q.size() == 3) begin
      mx = q[0][4] ? int'(q[1]) - 256 : int'(q[1]);
      my = q[0][5] ? int'(q[2]) - 256 : int'(q[2]);
      if (q[0][6]) mx = 0;
      if (q[0][7]) my = 0;
      rx = clampi(rx + mx, W - 1);
      ry = clampi(ry - my, H - 1);
      rb = q[0][0];
      exp_pv++;
      q.delete();
    end
  endtask

  task automatic send_bit(input bit v);
    @(negedge clk);
    ps2_data = v;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (6) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_byte(input bit [7:0] b, input bit bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1);
    repeat (4) @(negedge clk);
    model_byte(b, !bad_par);
  endtask

  task automatic send_pkt(input bit [7:0] b0, input bit [7:0] b1, input bit [7:0] b2);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int fe_before;
    bit [7:0] b;
    exp_pv = 0; exp_fe = 0;
    model_reset();
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset");

    send_pkt(8'h09, 8'h0A, 8'h05);
    check_all("pkt_basic");
    chk_eq("pkt_basic.x_const", int'(mouseX), 330);
    chk_eq("pkt_basic.y_const", int'(mouseY), 235);

    // drive x to 5, then a full negative swing on both axes
    do_reset();
    send_pkt(8'h18, 8'h00, 8'h00);
    send_pkt(8'h18, 8'hC5, 8'h00);
    chk_eq("to_five.x", int'(mouseX), 5);
    send_pkt(8'h38, 8'h00, 8'h00);
    check_all("neg_clamp");
    chk_eq("neg_clamp.x_const", int'(mouseX), 0);
    chk_eq("neg_clamp.y_const", int'(mouseY), 479);

    // positive saturation on the right/top
    send_pkt(8'h08, 8'hFF, 8'h7F);
    send_pkt(8'h08, 8'hFF, 8'hFF);
    send_pkt(8'h08, 8'hFF, 8'hFF);
    check_all("pos_clamp");
    chk_eq("pos_clamp.x_const", int'(mouseX), W - 1);
    chk_eq("pos_clamp.y_const", int'(mouseY), 0);

    do_reset();
    send_byte(8'h0A, 1'b1);
    check_all("bad_parity");
    send_pkt(8'h08, 8'h01, 8'h01);
    check_all("after_bad_parity");

    send_byte(8'h00, 1'b0);
    send_pkt(8'h08, 8'h02, 8'h00);
    check_all("resync");

    // partial frame then idle long enough to expire the timeout
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (TMO + 20) @(negedge clk);
    exp_fe++;
    q.delete();
    check_all("timeout");
    send_pkt(8'h08, 8'h03, 8'h02);
    check_all("after_timeout");

    send_pkt(8'h49, 8'h7F, 8'h00);
    check_all("x_ovf");

    // reset in the middle of a frame: no error pulse, back to center
    fe_before = fe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    do_reset();
    check_all("mid_reset");
    chk_eq("mid_reset.no_fe", fe_cnt, fe_before);
    send_pkt(8'h09, 8'h01, 8'h01);
    check_all("after_mid_reset");

    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(5) == 0) b = 8'($urandom);
      else                        b = 8'($urandom) | 8'h08;
      send_byte(b, $urandom_range(9) == 0);
      check_all("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
